// File: rtl/ps2_rx_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_e;

    localparam logic [7:0] KEYCODE_BREAK = 8'hF0;
    localparam logic [7:0] KEYCODE_EXT   = 8'hE0;

    // Idle level of both PS/2 lines; synchroniser and filter reset to this.
    localparam logic LINE_IDLE = 1'b1;

    // Odd parity holds when data plus parity contain an odd number of ones.
    function automatic logic parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_rx_filter.sv
// Synchroniser, glitch filter and falling-edge detector for the PS/2 clock line.
module ps2_filter
    import ps2_rx_pkg::*;
#(
    parameter int unsigned FILT_LEN = 4
) (
    input  logic clk_50,
    input  logic areset,
    input  logic line_i,
    output logic fall_o
);

    localparam int unsigned CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

    logic             meta_q;
    logic             sync_q;
    logic             level_q;
    logic [CNT_W-1:0] cnt_q;
    logic             fall_q;

    // Two-flop synchroniser for the asynchronous line.
    always_ff @(posedge clk_50 or posedge areset) begin
        if (areset) begin
            meta_q <= LINE_IDLE;
            sync_q <= LINE_IDLE;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
        end
    end

    // Accept a new level only after FILT_LEN consecutive differing samples; flag 1->0.
    always_ff @(posedge clk_50 or posedge areset) begin
        if (areset) begin
            level_q <= LINE_IDLE;
            cnt_q   <= '0;
            fall_q  <= 1'b0;
        end else begin
            fall_q <= 1'b0;
            if (sync_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q <= sync_q;
                cnt_q   <= '0;
                fall_q  <= ~sync_q;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign fall_o = fall_q;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: frames bytes, folds E0/F0 prefixes into ext/brk flags.
module ps2_rx
    import ps2_rx_pkg::*;
#(
    parameter int unsigned FILT_LEN    = 4,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk_50,
    input  logic       areset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] keycode,
    output logic       valid,
    output logic       brk,
    output logic       ext,
    output logic       err
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic             clk_fall;
    logic             dat_meta_q;
    logic             dat_sync_q;

    state_e           state_q;
    logic [2:0]       bitcnt_q;
    logic [7:0]       shift_q;
    logic             par_q;
    logic [TMO_W-1:0] tmo_q;
    logic             brk_pend_q;
    logic             ext_pend_q;
    logic [7:0]       keycode_q;
    logic             valid_q;
    logic             brk_q;
    logic             ext_q;
    logic             err_q;

    ps2_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_clk_filt (
        .clk_50 (clk_50),
        .areset (areset),
        .line_i (ps2_clk),
        .fall_o (clk_fall)
    );

    // Data line only needs synchronising; it is sampled long after it settles.
    always_ff @(posedge clk_50 or posedge areset) begin
        if (areset) begin
            dat_meta_q <= LINE_IDLE;
            dat_sync_q <= LINE_IDLE;
        end else begin
            dat_meta_q <= ps2_dat;
            dat_sync_q <= dat_meta_q;
        end
    end

    // Frame FSM with inactivity timeout and prefix tracking.
    always_ff @(posedge clk_50 or posedge areset) begin
        if (areset) begin
            state_q    <= ST_IDLE;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            brk_pend_q <= 1'b0;
            ext_pend_q <= 1'b0;
            keycode_q  <= 8'h00;
            valid_q    <= 1'b0;
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;

            if (state_q == ST_IDLE || clk_fall) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + TMO_W'(1);
            end

            if (clk_fall) begin
                case (state_q)
                    ST_IDLE: begin
                        if (!dat_sync_q) begin
                            state_q  <= ST_DATA;
                            bitcnt_q <= '0;
                        end
                    end
                    ST_DATA: begin
                        shift_q[bitcnt_q] <= dat_sync_q;
                        bitcnt_q          <= bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            state_q <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        par_q   <= dat_sync_q;
                        state_q <= ST_STOP;
                    end
                    ST_STOP: begin
                        state_q <= ST_IDLE;
                        if (dat_sync_q && parity_ok(shift_q, par_q)) begin
                            if (shift_q == KEYCODE_BREAK) begin
                                brk_pend_q <= 1'b1;
                            end else if (shift_q == KEYCODE_EXT) begin
                                ext_pend_q <= 1'b1;
                            end else begin
                                valid_q    <= 1'b1;
                                keycode_q  <= shift_q;
                                brk_q      <= brk_pend_q;
                                ext_q      <= ext_pend_q;
                                brk_pend_q <= 1'b0;
                                ext_pend_q <= 1'b0;
                            end
                        end else begin
                            err_q      <= 1'b1;
                            brk_pend_q <= 1'b0;
                            ext_pend_q <= 1'b0;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end else if (state_q != ST_IDLE && tmo_q == TMO_LAST) begin
                err_q      <= 1'b1;
                state_q    <= ST_IDLE;
                brk_pend_q <= 1'b0;
                ext_pend_q <= 1'b0;
            end
        end
    end

    assign keycode = keycode_q;
    assign valid   = valid_q;
    assign brk     = brk_q;
    assign ext     = ext_q;
    assign err     = err_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: transaction-level model of PS/2 frames and prefixes.
module tb_ps2_rx;

    localparam int FILT = 4;
    localparam int TMO  = 1000;
    localparam int HB   = 20;   // half PS/2 bit period in clk_50 cycles
    localparam int GAP  = 30;

    typedef struct {
        bit         is_err;
        logic [7:0] key;
        bit         brk;
        bit         ext;
        int         earliest;
        int         deadline;
    } exp_t;

    logic       clk_50 = 1'b0;
    logic       areset;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] keycode;
    logic       valid;
    logic       brk;
    logic       ext;
    logic       err;

    int         compared   = 0;
    int         mismatched = 0;
    int         cyc        = 0;
    exp_t       expq[$];
    exp_t       cur;
    logic [7:0] model_key  = 8'h00;
    bit         brk_p      = 1'b0;
    bit         ext_p      = 1'b0;
    int         valid_cnt  = 0;
    int         err_cnt    = 0;
    logic [7:0] last_key   = 8'h00;
    logic       last_brk   = 1'b0;
    logic       last_ext   = 1'b0;

    ps2_rx #(
        .FILT_LEN    (FILT),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk_50  (clk_50),
        .areset  (areset),
        .ps2_clk (ps2_clk),
        .ps2_dat (ps2_dat),
        .keycode (keycode),
        .valid   (valid),
        .brk     (brk),
        .ext     (ext),
        .err     (err)
    );

    always #10 clk_50 = ~clk_50;

    always @(posedge clk_50) cyc = cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every cycle: outputs must match the head of the expected-event queue.
    always @(negedge clk_50) begin
        if (!areset) begin
            compared++;
            if (valid && err) begin
                mismatched++;
                $display("FAIL exclusive: valid and err both high at cycle %0d", cyc);
            end
            if (valid || err) begin
                compared++;
                if (expq.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_event: valid=%0b err=%0b key=%0h at cycle %0d, none expected",
                             valid, err, keycode, cyc);
                end else begin
                    cur = expq.pop_front();
                    if (cur.is_err != err || cyc < cur.earliest ||
                        (valid && (keycode != cur.key || brk != cur.brk || ext != cur.ext))) begin
                        mismatched++;
                        $display("FAIL event: got err=%0b key=%0h brk=%0b ext=%0b cyc=%0d, expected err=%0b key=%0h brk=%0b ext=%0b cyc>=%0d",
                                 err, keycode, brk, ext, cyc, cur.is_err, cur.key, cur.brk, cur.ext, cur.earliest);
                    end
                    if (valid && !cur.is_err) model_key = cur.key;
                end
                if (valid) begin
                    valid_cnt++;
                    last_key = keycode;
                    last_brk = brk;
                    last_ext = ext;
                end
                if (err) err_cnt++;
            end else if (expq.size() > 0 && cyc > expq[0].deadline) begin
                compared++;
                mismatched++;
                $display("FAIL missing_event: expected err=%0b key=%0h by cycle %0d, got nothing",
                         expq[0].is_err, expq[0].key, expq[0].deadline);
                cur = expq.pop_front();
            end
            compared++;
            if (keycode != model_key) begin
                mismatched++;
                $display("FAIL keycode_hold: got %0h expected %0h at cycle %0d", keycode, model_key, cyc);
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_50);
        #2;
    endtask

    // Present one bit while the clock is high, then pull the clock low.
    task automatic drive_bit(input logic b, input bit glitch, output int fc);
        ps2_dat = b;
        if (glitch) begin
            wait_cyc(HB / 2);
            ps2_clk = 1'b0;
            wait_cyc(1);
            ps2_clk = 1'b1;
            wait_cyc(HB / 2 - 1);
        end else begin
            wait_cyc(HB);
        end
        ps2_clk = 1'b0;
        fc = cyc;
    endtask

    // Reference behaviour of a completed frame on the prefix state.
    task automatic model_frame(input logic [7:0] b, input bit bad, input int fc);
        exp_t e;
        e.is_err = bad; e.key = b; e.brk = brk_p; e.ext = ext_p;
        e.earliest = fc + 1;
        e.deadline = fc + FILT + 8;
        if (bad) begin
            expq.push_back(e);
            brk_p = 1'b0; ext_p = 1'b0;
        end else if (b == 8'hF0) begin
            brk_p = 1'b1;
        end else if (b == 8'hE0) begin
            ext_p = 1'b1;
        end else begin
            expq.push_back(e);
            brk_p = 1'b0; ext_p = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit glitch);
        logic [10:0] bits;
        logic        par;
        int          fc;
        par  = ~(^b) ^ bad_par;
        bits = {~bad_stop, par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            drive_bit(bits[i], glitch && (i % 3 == 1), fc);
            if (i == 10) model_frame(b, bad_par || bad_stop, fc);
            wait_cyc(HB);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
        wait_cyc(GAP);
    endtask

    // Start bit plus n data bits; clock left low after the last edge.
    task automatic partial_bits(input logic [7:0] b, input int n, output int fc);
        logic [7:0] d;
        d = b;
        drive_bit(1'b0, 1'b0, fc);
        for (int i = 0; i < n; i++) begin
            wait_cyc(HB);
            ps2_clk = 1'b1;
            drive_bit(d[i], 1'b0, fc);
        end
    endtask

    task automatic send_timeout(input logic [7:0] b, input int n);
        exp_t e;
        int   fc;
        partial_bits(b, n, fc);
        e.is_err = 1'b1; e.key = 8'h00; e.brk = 1'b0; e.ext = 1'b0;
        e.earliest = fc + TMO;
        e.deadline = fc + TMO + FILT + 20;
        expq.push_back(e);
        brk_p = 1'b0; ext_p = 1'b0;
        wait_cyc(HB);
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        wait_cyc(TMO + 30);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, e0, fc;
        logic [7:0] b;
        int r;

        areset  = 1'b1;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        wait_cyc(5);
        chk("reset_valid", valid, 0);
        chk("reset_err", err, 0);
        chk("reset_keycode", keycode, 8'h00);
        chk("reset_brk", brk, 0);
        chk("reset_ext", ext, 0);
        areset = 1'b0;
        wait_cyc(FILT + 10);

        // Plain make code
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'h1C, 0, 0, 0);
        chk("1c_count", valid_cnt - v0, 1);
        chk("1c_key", last_key, 8'h1C);
        chk("1c_brk", last_brk, 0);
        chk("1c_ext", last_ext, 0);
        chk("1c_noerr", err_cnt - e0, 0);

        // Break prefix then release clears
        v0 = valid_cnt;
        send_frame(8'hF0, 0, 0, 0);
        send_frame(8'h1C, 0, 0, 0);
        chk("f0_1c_count", valid_cnt - v0, 1);
        chk("f0_1c_key", last_key, 8'h1C);
        chk("f0_1c_brk", last_brk, 1);
        send_frame(8'h1C, 0, 0, 0);
        chk("1c_after_brk", last_brk, 0);

        // Extended break
        v0 = valid_cnt;
        send_frame(8'hE0, 0, 0, 0);
        send_frame(8'hF0, 0, 0, 0);
        send_frame(8'h74, 0, 0, 0);
        chk("e0f0_74_count", valid_cnt - v0, 1);
        chk("e0f0_74_key", last_key, 8'h74);
        chk("e0f0_74_ext", last_ext, 1);
        chk("e0f0_74_brk", last_brk, 1);

        // Parity error then recovery
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'h3A, 1, 0, 0);
        chk("par_err_count", err_cnt - e0, 1);
        chk("par_err_novalid", valid_cnt - v0, 0);
        send_frame(8'h22, 0, 0, 0);
        chk("after_par_key", last_key, 8'h22);
        chk("after_par_brk", last_brk, 0);

        // Timeout on a partial frame
        v0 = valid_cnt; e0 = err_cnt;
        send_timeout(8'h5B, 4);
        chk("tmo_err_count", err_cnt - e0, 1);
        chk("tmo_novalid", valid_cnt - v0, 0);
        send_frame(8'h1D, 0, 0, 0);
        chk("after_tmo_key", last_key, 8'h1D);

        // Glitched frame, then reset in the middle of the next one
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'h23, 0, 0, 1);
        chk("glitch_count", valid_cnt - v0, 1);
        chk("glitch_key", last_key, 8'h23);
        chk("glitch_noerr", err_cnt - e0, 0);
        v0 = valid_cnt; e0 = err_cnt;
        partial_bits(8'h5A, 5, fc);
        wait_cyc(HB);
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        areset  = 1'b1;
        wait_cyc(3);
        chk("mid_reset_keycode", keycode, 8'h00);
        chk("mid_reset_valid", valid, 0);
        chk("mid_reset_err", err, 0);
        model_key = 8'h00;
        brk_p = 1'b0; ext_p = 1'b0;
        expq.delete();
        areset = 1'b0;
        wait_cyc(FILT + 200);
        chk("post_reset_novalid", valid_cnt - v0, 0);
        chk("post_reset_noerr", err_cnt - e0, 0);
        chk("post_reset_keycode", keycode, 8'h00);

        // Randomised traffic
        for (int n = 0; n < 60; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2)       b = 8'hF0;
            else if (r == 2) b = 8'hE0;
            else             b = 8'($urandom);
            send_frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
                       $urandom_range(0, 3) == 0);
        end

        wait_cyc(50);
        chk("queue_drained", expq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
